// File: rtl/axi4_arbiter_pkg.sv
// Shared types and constants for the 2:1 AXI4 arbiter.
// IFU is read-only; LSU reads and writes through the same sram port.
package axi4_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [3:0] IFU_ID_DEF = 4'd0;
  localparam logic [3:0] LSU_ID_DEF = 4'd1;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/axi4_arbiter_rr2.sv
// Two-way request/grant picker for the arbiter.
// Remembers the last owner; ties go round-robin or to the LSU.
module arb_rr2
  import axi4_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic upd,
  input  logic upd_owner,
  output logic gnt_ifu,
  output logic gnt_lsu
);

  logic last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= GNT_LSU;
    end else if (upd) begin
      last_q <= upd_owner;
    end
  end

  always_comb begin
    gnt_ifu = 1'b0;
    gnt_lsu = 1'b0;
    unique case (1'b1)
      (req_ifu & req_lsu): begin
        if (RR_EN && last_q == GNT_LSU) gnt_ifu = 1'b1;
        else                            gnt_lsu = 1'b1;
      end
      (req_ifu & ~req_lsu): gnt_ifu = 1'b1;
      (~req_ifu & req_lsu): gnt_lsu = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/axi4_arbiter.sv
// 2:1 AXI4 arbiter: IFU and LSU masters onto the single sram slave.
// One whole transaction per grant; channels pass through unbuffered.
module axi4_arbiter
  import axi4_arbiter_pkg::*;
#(
  parameter bit         RR_EN  = 1'b1,
  parameter logic [3:0] IFU_ID = IFU_ID_DEF,
  parameter logic [3:0] LSU_ID = LSU_ID_DEF
) (
  input  logic        clock,
  input  logic        reset,
  // IFU
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  input  logic [7:0]  ifu_arlen,
  input  logic [2:0]  ifu_arsize,
  input  logic [1:0]  ifu_arburst,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        ifu_rlast,
  output logic [3:0]  ifu_rid,
  output logic        ifu_awready,
  output logic        ifu_wready,
  output logic        ifu_bvalid,
  // LSU
  input  logic        lsu_arvalid,
  output logic        lsu_arready,
  input  logic [31:0] lsu_araddr,
  input  logic [7:0]  lsu_arlen,
  input  logic [2:0]  lsu_arsize,
  input  logic [1:0]  lsu_arburst,
  output logic        lsu_rvalid,
  input  logic        lsu_rready,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  output logic        lsu_rlast,
  output logic [3:0]  lsu_rid,
  input  logic        lsu_awvalid,
  output logic        lsu_awready,
  input  logic [31:0] lsu_awaddr,
  input  logic [7:0]  lsu_awlen,
  input  logic [2:0]  lsu_awsize,
  input  logic [1:0]  lsu_awburst,
  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic        lsu_wlast,
  output logic        lsu_bvalid,
  input  logic        lsu_bready,
  output logic [1:0]  lsu_bresp,
  output logic [3:0]  lsu_bid,
  // sram
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  output logic [3:0]  mem_arid,
  output logic [7:0]  mem_arlen,
  output logic [2:0]  mem_arsize,
  output logic [1:0]  mem_arburst,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rlast,
  input  logic [3:0]  mem_rid,
  output logic        mem_awvalid,
  input  logic        mem_awready,
  output logic [31:0] mem_awaddr,
  output logic [3:0]  mem_awid,
  output logic [7:0]  mem_awlen,
  output logic [2:0]  mem_awsize,
  output logic [1:0]  mem_awburst,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_wlast,
  input  logic        mem_bvalid,
  output logic        mem_bready,
  input  logic [1:0]  mem_bresp,
  input  logic [3:0]  mem_bid
);

  arb_state_t state_q, state_d;
  logic       addr_done_q;
  logic       gnt_ifu, gnt_lsu;
  logic       ahs, done;

  assign ifu_awready = 1'b0;
  assign ifu_wready  = 1'b0;
  assign ifu_bvalid  = 1'b0;

  arb_rr2 #(.RR_EN(RR_EN)) u_pick (
    .clock     (clock),
    .reset     (reset),
    .req_ifu   (ifu_arvalid),
    .req_lsu   (lsu_arvalid | lsu_awvalid),
    .upd       (done),
    .upd_owner (state_q != IFU_RD),
    .gnt_ifu   (gnt_ifu),
    .gnt_lsu   (gnt_lsu)
  );

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    ifu_rlast   = 1'b0;
    ifu_rid     = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_rlast   = 1'b0;
    lsu_rid     = '0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    lsu_bid     = '0;
    mem_arvalid = 1'b0;
    mem_araddr  = '0;
    mem_arid    = '0;
    mem_arlen   = '0;
    mem_arsize  = '0;
    mem_arburst = '0;
    mem_rready  = 1'b0;
    mem_awvalid = 1'b0;
    mem_awaddr  = '0;
    mem_awid    = '0;
    mem_awlen   = '0;
    mem_awsize  = '0;
    mem_awburst = '0;
    mem_wvalid  = 1'b0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_wlast   = 1'b0;
    mem_bready  = 1'b0;
    unique case (state_q)
      IFU_RD: begin
        mem_arvalid = ifu_arvalid & ~addr_done_q;
        ifu_arready = mem_arready & ~addr_done_q;
        mem_araddr  = ifu_araddr;
        mem_arid    = IFU_ID;
        mem_arlen   = ifu_arlen;
        mem_arsize  = ifu_arsize;
        mem_arburst = ifu_arburst;
        ifu_rvalid  = mem_rvalid;
        ifu_rdata   = mem_rdata;
        ifu_rresp   = mem_rresp;
        ifu_rlast   = mem_rlast;
        ifu_rid     = mem_rid;
        mem_rready  = ifu_rready;
      end
      LSU_RD: begin
        mem_arvalid = lsu_arvalid & ~addr_done_q;
        lsu_arready = mem_arready & ~addr_done_q;
        mem_araddr  = lsu_araddr;
        mem_arid    = LSU_ID;
        mem_arlen   = lsu_arlen;
        mem_arsize  = lsu_arsize;
        mem_arburst = lsu_arburst;
        lsu_rvalid  = mem_rvalid;
        lsu_rdata   = mem_rdata;
        lsu_rresp   = mem_rresp;
        lsu_rlast   = mem_rlast;
        lsu_rid     = mem_rid;
        mem_rready  = lsu_rready;
      end
      LSU_WR: begin
        mem_awvalid = lsu_awvalid & ~addr_done_q;
        lsu_awready = mem_awready & ~addr_done_q;
        mem_awaddr  = lsu_awaddr;
        mem_awid    = LSU_ID;
        mem_awlen   = lsu_awlen;
        mem_awsize  = lsu_awsize;
        mem_awburst = lsu_awburst;
        mem_wvalid  = lsu_wvalid;
        mem_wdata   = lsu_wdata;
        mem_wstrb   = lsu_wstrb;
        mem_wlast   = lsu_wlast;
        lsu_wready  = mem_wready;
        lsu_bvalid  = mem_bvalid;
        lsu_bresp   = mem_bresp;
        lsu_bid     = mem_bid;
        mem_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

  assign ahs  = (mem_arvalid & mem_arready)
              | (mem_awvalid & mem_awready);
  assign done = (state_q == LSU_WR)
              ? (mem_bvalid & mem_bready)
              : (mem_rvalid & mem_rready & mem_rlast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_ifu)      state_d = IFU_RD;
        else if (gnt_lsu) state_d = lsu_arvalid ? LSU_RD : LSU_WR;
      end
      IFU_RD, LSU_RD, LSU_WR: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (done)     addr_done_q <= 1'b0;
      else if (ahs) addr_done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_arbiter.sv
// Directed bench for axi4_arbiter: grants, bursts, writes, reset.
// Second instance with RR_EN=0 checks fixed LSU priority.
module tb_axi4_arbiter;
  import axi4_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        ifu_arvalid, ifu_rready;
  logic [31:0] ifu_araddr;
  logic [7:0]  ifu_arlen;
  logic [2:0]  ifu_arsize;
  logic [1:0]  ifu_arburst;
  logic        lsu_arvalid, lsu_rready, lsu_awvalid;
  logic        lsu_wvalid, lsu_wlast, lsu_bready;
  logic [31:0] lsu_araddr, lsu_awaddr, lsu_wdata;
  logic [7:0]  lsu_arlen, lsu_awlen;
  logic [2:0]  lsu_arsize, lsu_awsize;
  logic [1:0]  lsu_arburst, lsu_awburst;
  logic [3:0]  lsu_wstrb;
  logic        mem_arready, mem_rvalid, mem_rlast;
  logic        mem_awready, mem_wready, mem_bvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp, mem_bresp;
  logic [3:0]  mem_rid, mem_bid;

  logic        ifu_arready, ifu_rvalid, ifu_rlast;
  logic        ifu_awready, ifu_wready, ifu_bvalid;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic [3:0]  ifu_rid;
  logic        lsu_arready, lsu_rvalid, lsu_rlast;
  logic        lsu_awready, lsu_wready, lsu_bvalid;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp, lsu_bresp;
  logic [3:0]  lsu_rid, lsu_bid;
  logic        mem_arvalid, mem_rready, mem_awvalid;
  logic        mem_wvalid, mem_wlast, mem_bready;
  logic [31:0] mem_araddr, mem_awaddr, mem_wdata;
  logic [3:0]  mem_arid, mem_awid, mem_wstrb;
  logic [7:0]  mem_arlen, mem_awlen;
  logic [2:0]  mem_arsize, mem_awsize;
  logic [1:0]  mem_arburst, mem_awburst;

  logic        fp_ifu_arready, fp_ifu_rvalid, fp_ifu_rlast;
  logic        fp_ifu_awready, fp_ifu_wready, fp_ifu_bvalid;
  logic [31:0] fp_ifu_rdata;
  logic [1:0]  fp_ifu_rresp;
  logic [3:0]  fp_ifu_rid;
  logic        fp_lsu_arready, fp_lsu_rvalid, fp_lsu_rlast;
  logic        fp_lsu_awready, fp_lsu_wready, fp_lsu_bvalid;
  logic [31:0] fp_lsu_rdata;
  logic [1:0]  fp_lsu_rresp, fp_lsu_bresp;
  logic [3:0]  fp_lsu_rid, fp_lsu_bid;
  logic        fp_mem_arvalid, fp_mem_rready, fp_mem_awvalid;
  logic        fp_mem_wvalid, fp_mem_wlast, fp_mem_bready;
  logic [31:0] fp_mem_araddr, fp_mem_awaddr, fp_mem_wdata;
  logic [3:0]  fp_mem_arid, fp_mem_awid, fp_mem_wstrb;
  logic [7:0]  fp_mem_arlen, fp_mem_awlen;
  logic [2:0]  fp_mem_arsize, fp_mem_awsize;
  logic [1:0]  fp_mem_arburst, fp_mem_awburst;

  axi4_arbiter #(.RR_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rlast(ifu_rlast), .ifu_rid(ifu_rid),
    .ifu_awready(ifu_awready), .ifu_wready(ifu_wready),
    .ifu_bvalid(ifu_bvalid),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rlast(lsu_rlast), .lsu_rid(lsu_rid),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wlast(lsu_wlast), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
    .lsu_bid(lsu_bid),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_araddr(mem_araddr), .mem_arid(mem_arid),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
    .mem_arburst(mem_arburst), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
    .mem_rid(mem_rid), .mem_awvalid(mem_awvalid),
    .mem_awready(mem_awready), .mem_awaddr(mem_awaddr),
    .mem_awid(mem_awid), .mem_awlen(mem_awlen),
    .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_wlast(mem_wlast), .mem_bvalid(mem_bvalid),
    .mem_bready(mem_bready), .mem_bresp(mem_bresp),
    .mem_bid(mem_bid)
  );

  axi4_arbiter #(.RR_EN(1'b0)) fp (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(fp_ifu_arready),
    .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen),
    .ifu_arsize(ifu_arsize), .ifu_arburst(ifu_arburst),
    .ifu_rvalid(fp_ifu_rvalid), .ifu_rready(ifu_rready),
    .ifu_rdata(fp_ifu_rdata), .ifu_rresp(fp_ifu_rresp),
    .ifu_rlast(fp_ifu_rlast), .ifu_rid(fp_ifu_rid),
    .ifu_awready(fp_ifu_awready), .ifu_wready(fp_ifu_wready),
    .ifu_bvalid(fp_ifu_bvalid),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(fp_lsu_arready),
    .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen),
    .lsu_arsize(lsu_arsize), .lsu_arburst(lsu_arburst),
    .lsu_rvalid(fp_lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_rdata(fp_lsu_rdata), .lsu_rresp(fp_lsu_rresp),
    .lsu_rlast(fp_lsu_rlast), .lsu_rid(fp_lsu_rid),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(fp_lsu_awready),
    .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen),
    .lsu_awsize(lsu_awsize), .lsu_awburst(lsu_awburst),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(fp_lsu_wready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wlast(lsu_wlast), .lsu_bvalid(fp_lsu_bvalid),
    .lsu_bready(lsu_bready), .lsu_bresp(fp_lsu_bresp),
    .lsu_bid(fp_lsu_bid),
    .mem_arvalid(fp_mem_arvalid), .mem_arready(mem_arready),
    .mem_araddr(fp_mem_araddr), .mem_arid(fp_mem_arid),
    .mem_arlen(fp_mem_arlen), .mem_arsize(fp_mem_arsize),
    .mem_arburst(fp_mem_arburst), .mem_rvalid(mem_rvalid),
    .mem_rready(fp_mem_rready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
    .mem_rid(mem_rid), .mem_awvalid(fp_mem_awvalid),
    .mem_awready(mem_awready), .mem_awaddr(fp_mem_awaddr),
    .mem_awid(fp_mem_awid), .mem_awlen(fp_mem_awlen),
    .mem_awsize(fp_mem_awsize), .mem_awburst(fp_mem_awburst),
    .mem_wvalid(fp_mem_wvalid), .mem_wready(mem_wready),
    .mem_wdata(fp_mem_wdata), .mem_wstrb(fp_mem_wstrb),
    .mem_wlast(fp_mem_wlast), .mem_bvalid(mem_bvalid),
    .mem_bready(fp_mem_bready), .mem_bresp(mem_bresp),
    .mem_bid(mem_bid)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic beat(logic [31:0] d, logic last);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    mem_rlast  = last;
  endtask

  initial begin
    reset = 1'b1;
    {ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready} = '0;
    {lsu_awvalid, lsu_wvalid, lsu_wlast, lsu_bready} = '0;
    ifu_araddr = '0; ifu_arlen = '0; ifu_arsize = 3'd2;
    ifu_arburst = BURST_INCR;
    lsu_araddr = '0; lsu_arlen = '0; lsu_arsize = 3'd2;
    lsu_arburst = BURST_INCR;
    lsu_awaddr = '0; lsu_awlen = '0; lsu_awsize = 3'd2;
    lsu_awburst = BURST_INCR;
    lsu_wdata = '0; lsu_wstrb = '0;
    {mem_arready, mem_rvalid, mem_rlast} = '0;
    {mem_awready, mem_wready, mem_bvalid} = '0;
    mem_rdata = '0; mem_rresp = '0; mem_bresp = '0;
    mem_rid = '0; mem_bid = '0;
    cyc(); cyc();
    #1;
    check("rst_arvalid", mem_arvalid, 0);
    check("rst_ifu_arready", ifu_arready, 0);
    check("rst_lsu_awready", lsu_awready, 0);
    check("rst_ifu_tieoff", {ifu_awready, ifu_wready, ifu_bvalid}, 0);

    // first tie after reset: IFU, then LSU
    reset = 1'b0;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0200;
    mem_arready = 1; ifu_rready = 1; lsu_rready = 1;
    #1;
    check("idle_no_comb", mem_arvalid, 0);
    cyc(); #1;
    check("tie1_arid", mem_arid, 0);
    check("tie1_araddr", mem_araddr, 32'h8000_0100);
    check("tie1_ifu_rdy", ifu_arready, 1);
    check("tie1_lsu_rdy", lsu_arready, 0);
    cyc();
    ifu_arvalid = 0; beat(32'hA1, 1); #1;
    check("tie1_addr_once", mem_arvalid, 0);
    check("tie1_ifu_rvalid", ifu_rvalid, 1);
    check("tie1_ifu_rdata", ifu_rdata, 32'hA1);
    check("tie1_lsu_rvalid", lsu_rvalid, 0);
    cyc();
    mem_rvalid = 0; #1;
    check("tie1_gap", lsu_arready, 0);
    cyc(); #1;
    check("tie1b_arid", mem_arid, 1);
    check("tie1b_araddr", mem_araddr, 32'h8000_0200);
    check("tie1b_lsu_rdy", lsu_arready, 1);
    cyc();
    lsu_arvalid = 0; beat(32'hB2, 1); #1;
    check("tie1b_rdata", lsu_rdata, 32'hB2);
    check("tie1b_ifu_rv", ifu_rvalid, 0);
    cyc();
    mem_rvalid = 0;

    // lone IFU read, fixed burst
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
    ifu_arburst = BURST_FIXED;
    cyc(); #1;
    check("ifu_arvalid", mem_arvalid, 1);
    check("ifu_araddr", mem_araddr, 32'h8000_0000);
    check("ifu_arburst", mem_arburst, BURST_FIXED);
    cyc();
    ifu_arvalid = 0; ifu_arburst = BURST_INCR;
    beat(32'h1234_5678, 1); #1;
    check("ifu_rdata", ifu_rdata, 32'h1234_5678);
    check("ifu_rlast", ifu_rlast, 1);
    check("ifu_rready", mem_rready, 1);
    cyc(); #1;
    check("ifu_done_idle", ifu_rvalid, 0);
    mem_rvalid = 0;

    // second tie: LSU wins after an IFU grant
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0104;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0204;
    cyc(); #1;
    check("tie2_arid", mem_arid, 1);
    check("tie2_ifu_rdy", ifu_arready, 0);
    cyc();
    lsu_arvalid = 0; beat(32'hC3, 1);
    cyc();
    mem_rvalid = 0;
    cyc(); #1;
    check("tie2b_arid", mem_arid, 0);
    cyc();
    ifu_arvalid = 0; beat(32'hC4, 1);
    cyc();
    mem_rvalid = 0;

    // LSU write with IFU waiting
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0300;
    mem_awready = 1;
    cyc(); #1;
    check("wr_awvalid", mem_awvalid, 1);
    check("wr_awaddr", mem_awaddr, 32'h8000_0010);
    check("wr_awid", mem_awid, 1);
    check("wr_awready", lsu_awready, 1);
    check("wr_no_ar", mem_arvalid, 0);
    cyc();
    lsu_awvalid = 0; lsu_wvalid = 1; lsu_wdata = 32'hDEAD_BEEF;
    lsu_wstrb = 4'hF; lsu_wlast = 1; mem_wready = 1; #1;
    check("wr_wvalid", mem_wvalid, 1);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_wstrb", mem_wstrb, 4'hF);
    check("wr_wready", lsu_wready, 1);
    check("wr_aw_once", mem_awvalid, 0);
    cyc();
    lsu_wvalid = 0; mem_bvalid = 1; lsu_bready = 1; #1;
    check("wr_bvalid", lsu_bvalid, 1);
    check("wr_bready", mem_bready, 1);
    check("wr_ifu_held", ifu_arready, 0);
    cyc();
    mem_bvalid = 0; #1;
    check("wr_gap", ifu_arready, 0);
    cyc(); #1;
    check("wr_ifu_next", ifu_arready, 1);
    check("wr_ifu_addr", mem_araddr, 32'h8000_0300);
    cyc();
    ifu_arvalid = 0; beat(32'hD5, 1);
    cyc();
    mem_rvalid = 0;

    // LSU INCR burst of 4 beats with IFU pending
    lsu_arvalid = 1; lsu_araddr = 32'h8000_0400;
    lsu_arlen = 8'd3; lsu_arburst = BURST_INCR;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0500;
    cyc(); #1;
    check("bu_arlen", mem_arlen, 3);
    check("bu_arburst", mem_arburst, BURST_INCR);
    check("bu_arid", mem_arid, 1);
    cyc();
    lsu_arvalid = 0; lsu_arlen = 0;
    for (int i = 0; i < 4; i++) begin
      beat(32'h100 + i, i == 3); #1;
      check($sformatf("bu_rdata%0d", i), lsu_rdata, 32'h100 + i);
      check($sformatf("bu_rlast%0d", i), lsu_rlast, i == 3);
      check($sformatf("bu_ifu_rv%0d", i), ifu_rvalid, 0);
      cyc();
    end
    mem_rvalid = 0; mem_rlast = 0;
    cyc(); #1;
    check("bu_ifu_after", ifu_arready, 1);
    cyc();
    ifu_arvalid = 0; beat(32'hE6, 1);
    cyc();
    mem_rvalid = 0;

    // reset in the middle of a write burst
    lsu_awvalid = 1; lsu_awaddr = 32'h8000_0020; lsu_awlen = 1;
    cyc();
    cyc();
    lsu_awvalid = 0; lsu_wvalid = 1; lsu_wlast = 0;
    mem_wready = 0; #1;
    check("rw_wvalid", mem_wvalid, 1);
    reset = 1;
    cyc();
    reset = 0; #1;
    check("rw_wvalid0", mem_wvalid, 0);
    check("rw_awvalid0", mem_awvalid, 0);
    check("rw_wready0", lsu_wready, 0);
    lsu_wvalid = 0; lsu_awlen = 0;
    ifu_arvalid = 1; ifu_araddr = 32'h8000_0600;
    cyc(); #1;
    check("rw_ifu_arvalid", mem_arvalid, 1);
    check("rw_ifu_araddr", mem_araddr, 32'h8000_0600);
    cyc();
    ifu_arvalid = 0; beat(32'hF7, 1); #1;
    check("rw_ifu_rdata", ifu_rdata, 32'hF7);
    cyc();
    mem_rvalid = 0;

    // continuous requests: RR alternates, fixed priority keeps LSU
    reset = 1;
    cyc();
    reset = 0;
    ifu_arvalid = 1; lsu_arvalid = 1;
    beat(32'h55, 1); #1;
    check("cont_idle", mem_arvalid, 0);
    check("cont_fp_idle", fp_mem_arvalid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      check($sformatf("rr_arid%0d", k), mem_arid, (k % 2));
      check($sformatf("fp_arid%0d", k), fp_mem_arid, 1);
      check($sformatf("fp_ifu_rv%0d", k), fp_ifu_rvalid, 0);
      cyc(); #1;
      check($sformatf("rr_gap%0d", k), mem_arvalid, 0);
      check($sformatf("fp_gap%0d", k), fp_mem_arvalid, 0);
    end
    ifu_arvalid = 0; lsu_arvalid = 0; mem_rvalid = 0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
